// File: rtl/uart_tx_fifo_serializer.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo_serializer
//
// Byte-oriented UART transmitter with an internal TX FIFO. Bytes arrive on a
// valid/ready write port, are queued, and are sent LSB first as asynchronous
// frames (start bit, 8 data bits, STOP_BITS stop bits). Frames from a
// non-empty FIFO follow each other with no idle gap.
//
// Optional feature (compile-time macro UART_TX_PARITY_EN):
//   defined   - an even-parity bit is inserted between the data and stop bits
//   undefined - plain 8N1 / 8N2 framing
//
// Parameters:
//   CLK_HZ      system clock frequency in Hz
//   BAUD        line bit rate
//   FIFO_DEPTH  FIFO entries, power of two in 2..256
//   STOP_BITS   1 or 2
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   wr_en       write strobe; byte accepted when wr_en && wr_ready
//   wr_data     byte to enqueue
//   wr_ready    FIFO not full
//   fifo_count  bytes queued, excluding the byte on the line
//   tx_busy     high while a frame is on the line
//   overflow    sticky; set by a write attempt while full
//   uart_tx     registered serial output, idles high
// ---------------------------------------------------------------------------
module uart_tx_fifo_serializer #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16,
    parameter int STOP_BITS  = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [7:0]                    wr_data,
    output logic                          wr_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          tx_busy,
    output logic                          overflow,
    output logic                          uart_tx
);

    // Rounded clock cycles per bit.
    localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int PW  = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int NW  = $clog2(FIFO_DEPTH) + 1;

    if (DIV < 2) begin : g_div_check
        $error("uart_tx_fifo_serializer: baud divisor must be at least 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_stop_check
        $error("uart_tx_fifo_serializer: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 256 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
        $error("uart_tx_fifo_serializer: FIFO_DEPTH must be a power of two in 2..256");
    end

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t          r_state;
    state_t          w_state_next;
    logic [CW-1:0]   r_baud_cnt;
    logic            w_bit_done;
    logic [2:0]      r_bit_idx;
    logic [2:0]      w_bit_idx_next;
    logic [7:0]      r_shreg;
    logic [7:0]      w_shreg_next;
    logic            r_uart_tx;
    logic            w_tx_next;
`ifdef UART_TX_PARITY_EN
    logic            r_parity;
    logic            w_parity_next;
`endif

    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [NW-1:0]   r_count;
    logic            r_overflow;
    logic            w_push;
    logic            w_pop;
    logic            w_fifo_has;
    logic [7:0]      w_rd_data;

    // Full/empty come from the occupancy count, so pointer equality is never
    // ambiguous. A pop in the same cycle does not make room for a write.
    assign wr_ready   = (r_count != NW'(FIFO_DEPTH));
    assign w_push     = wr_en && wr_ready;
    assign w_fifo_has = (r_count != '0);
    assign w_rd_data  = r_mem[r_rptr];
    assign w_bit_done = (r_baud_cnt == CW'(DIV - 1));

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values and simulation order cannot matter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state, pop request and next line value
    // ------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_state_next   = r_state;
        w_pop          = 1'b0;
        w_shreg_next   = r_shreg;
        w_bit_idx_next = r_bit_idx;
        w_tx_next      = 1'b1;
`ifdef UART_TX_PARITY_EN
        w_parity_next  = r_parity;
`endif

        case (r_state)
            S_IDLE: begin
                if (w_fifo_has) begin
                    w_pop        = 1'b1;
                    w_shreg_next = w_rd_data;
`ifdef UART_TX_PARITY_EN
                    w_parity_next = ^w_rd_data;
`endif
                    w_state_next = S_START;
                end
            end
            S_START: begin
                if (w_bit_done) begin
                    w_state_next   = S_DATA;
                    w_bit_idx_next = 3'd0;
                end
            end
            S_DATA: begin
                if (w_bit_done) begin
                    w_shreg_next = {1'b0, r_shreg[7:1]};
                    if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_state_next = S_PARITY;
`else
                        w_state_next = S_STOP;
`endif
                        w_bit_idx_next = 3'd0;
                    end else begin
                        w_bit_idx_next = r_bit_idx + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_bit_done) begin
                    w_state_next   = S_STOP;
                    w_bit_idx_next = 3'd0;
                end
            end
`endif
            S_STOP: begin
                if (w_bit_done) begin
                    w_bit_idx_next = 3'd0;
                    if (r_bit_idx == 3'(STOP_BITS - 1)) begin
                        // Chain straight into the next start bit when data waits.
                        if (w_fifo_has) begin
                            w_pop        = 1'b1;
                            w_shreg_next = w_rd_data;
`ifdef UART_TX_PARITY_EN
                            w_parity_next = ^w_rd_data;
`endif
                            w_state_next = S_START;
                        end else begin
                            w_state_next = S_IDLE;
                        end
                    end else begin
                        w_bit_idx_next = r_bit_idx + 3'd1;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase

        // The line is registered from the next state so it changes on the
        // same edge as the state itself.
        case (w_state_next)
            S_START:  w_tx_next = 1'b0;
            S_DATA:   w_tx_next = w_shreg_next[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: w_tx_next = w_parity_next;
`endif
            default:  w_tx_next = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Bit timing, shift register and line register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_baud_cnt <= '0;
            r_bit_idx  <= 3'd0;
            r_shreg    <= 8'h00;
            r_uart_tx  <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            if (r_state == S_IDLE || w_bit_done) begin
                r_baud_cnt <= '0;
            end else begin
                r_baud_cnt <= r_baud_cnt + CW'(1);
            end
            r_bit_idx <= w_bit_idx_next;
            r_shreg   <= w_shreg_next;
            r_uart_tx <= w_tx_next;
`ifdef UART_TX_PARITY_EN
            r_parity  <= w_parity_next;
`endif
        end
    end

    // ------------------------------------------------------------------
    // FIFO storage
    // ------------------------------------------------------------------
    // NOTE: the storage array has no reset; an entry is only read after it
    // has been written, and leaving it unreset lets it map onto RAM.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            // Power-of-two depth: pointers wrap naturally.
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + NW'(1);
                2'b01:   r_count <= r_count - NW'(1);
                default: r_count <= r_count;
            endcase
            if (wr_en && !wr_ready) r_overflow <= 1'b1;
        end
    end

    assign fifo_count = r_count;
    assign tx_busy    = (r_state != S_IDLE);
    assign overflow   = r_overflow;
    assign uart_tx    = r_uart_tx;

endmodule

// File: tb/tb_uart_tx_fifo_serializer.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_fifo_serializer
//
// Two instances at DIV=10: dut_a (FIFO_DEPTH=16) for framing, bursts,
// push/pop collision and mid-frame reset; dut_b (FIFO_DEPTH=4) for the
// full/overflow scenario. Writers push expected bytes into per-instance
// queues; monitors decode each frame off the line and pop/compare.
// ---------------------------------------------------------------------------
module tb_uart_tx_fifo_serializer;

    localparam int DIV = 10;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int FRAME_CYC = FB * DIV;

    logic       clk = 1'b0;
    logic       rst_a = 1'b1, rst_b = 1'b1;
    logic       wr_en_a = 1'b0, wr_en_b = 1'b0;
    logic [7:0] wr_data_a = 8'h00, wr_data_b = 8'h00;
    logic       wr_ready_a, wr_ready_b;
    logic [4:0] cnt_a;
    logic [2:0] cnt_b;
    logic       busy_a, busy_b, ovf_a, ovf_b, tx_a, tx_b;

    int n_vec = 0;
    int n_err = 0;
    int frames_a = 0;
    int frames_b = 0;
    logic [10:0] last_bits_a = '1;
    logic [7:0]  exp_a[$];
    logic [7:0]  exp_b[$];

    always #5 clk = ~clk;

    uart_tx_fifo_serializer #(
        .CLK_HZ(1_000_000), .BAUD(100_000), .FIFO_DEPTH(16), .STOP_BITS(1)
    ) dut_a (
        .clk(clk), .rst(rst_a), .wr_en(wr_en_a), .wr_data(wr_data_a),
        .wr_ready(wr_ready_a), .fifo_count(cnt_a), .tx_busy(busy_a),
        .overflow(ovf_a), .uart_tx(tx_a)
    );

    uart_tx_fifo_serializer #(
        .CLK_HZ(1_000_000), .BAUD(100_000), .FIFO_DEPTH(4), .STOP_BITS(1)
    ) dut_b (
        .clk(clk), .rst(rst_b), .wr_en(wr_en_b), .wr_data(wr_data_b),
        .wr_ready(wr_ready_b), .fifo_count(cnt_b), .tx_busy(busy_b),
        .overflow(ovf_b), .uart_tx(tx_b)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic report_fail(input string name, input logic [31:0] got);
        n_vec++;
        n_err++;
        $display("FAIL %s: got 0x%0h, nothing expected at %0t", name, got, $time);
    endtask

    function automatic logic line_of(input bit w);
        return w ? tx_b : tx_a;
    endfunction

    function automatic logic rst_of(input bit w);
        return w ? rst_b : rst_a;
    endfunction

    function automatic logic active_of(input bit w);
        return w ? (busy_b || cnt_b != 3'd0) : (busy_a || cnt_a != 5'd0);
    endfunction

    // Write one byte; accepted on the next rising edge if the DUT is ready.
    task automatic wr(input bit w, input logic [7:0] d, input bit push);
        if (w) begin
            wr_en_b = 1'b1; wr_data_b = d;
            if (push) exp_b.push_back(d);
        end else begin
            wr_en_a = 1'b1; wr_data_a = d;
            if (push) exp_a.push_back(d);
        end
        @(posedge clk); #1;
        if (w) wr_en_b = 1'b0; else wr_en_a = 1'b0;
    endtask

    task automatic wait_idle(input bit w, input string name);
        int g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (active_of(w) && g < 5000);
        if (g >= 5000) report_fail(name, 32'(g));
        repeat (3) @(negedge clk);
    endtask

    // Counts consecutive negedges with busy_a high, starting at the current one.
    task automatic measure_busy(output int n);
        n = 0;
        while (busy_a === 1'b1 && n < 5000) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Frame monitor: detect start bit, sample at bit centres, compare.
    task automatic mon(input bit w);
        logic [10:0] bits;
        logic [7:0]  data;
        logic [7:0]  exp;
        bit          aborted;
        bit          have;
        forever begin
            @(negedge clk);
            if (rst_of(w) || line_of(w) !== 1'b0) continue;
            bits = '1;
            aborted = 1'b0;
            for (int b = 0; b < FB; b++) begin
                for (int c = 0; c < ((b == 0) ? DIV / 2 : DIV); c++) begin
                    @(negedge clk);
                    if (rst_of(w)) aborted = 1'b1;
                end
                bits[b] = line_of(w);
            end
            if (aborted) continue;
            data = bits[8:1];
            have = 1'b0;
            exp  = 8'h00;
            if (w) begin
                frames_b++;
                if (exp_b.size() == 0) report_fail("unexpected_frame_b", 32'(data));
                else begin exp = exp_b.pop_front(); have = 1'b1; end
            end else begin
                frames_a++;
                last_bits_a = bits;
                if (exp_a.size() == 0) report_fail("unexpected_frame_a", 32'(data));
                else begin exp = exp_a.pop_front(); have = 1'b1; end
            end
            if (have) begin
                check(w ? "frame_data_b" : "frame_data_a", 32'(data), 32'(exp));
`ifdef UART_TX_PARITY_EN
                check("framing_start_par_stop", 32'({bits[0], bits[9], bits[10]}),
                      32'({1'b0, ^exp, 1'b1}));
`else
                check("framing_start_stop", 32'({bits[0], bits[9]}), 32'(2'b01));
`endif
            end
        end
    endtask

    initial begin
        fork
            mon(1'b0);
            mon(1'b1);
        join_none
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n_busy;
        int peak;
        int hi;
        logic [7:0] hello [7];
        hello = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h0D, 8'h0A};

        // ---------------- reset values ----------------
        repeat (3) @(negedge clk);
        check("reset_a", 32'({tx_a, wr_ready_a, cnt_a, busy_a, ovf_a}), 32'({1'b1, 1'b1, 5'd0, 1'b0, 1'b0}));
        check("reset_b", 32'({tx_b, wr_ready_b, cnt_b, busy_b, ovf_b}), 32'({1'b1, 1'b1, 3'd0, 1'b0, 1'b0}));
        @(posedge clk); #1;
        rst_a = 1'b0; rst_b = 1'b0;
        repeat (2) @(posedge clk); #1;

        // ---------------- single byte 0x48 ----------------
        wr(1'b0, 8'h48, 1'b1);
        @(negedge clk);
        check("accepted_state", 32'({tx_a, busy_a, cnt_a}), 32'({1'b1, 1'b0, 5'd1}));
        @(negedge clk);
        check("start_fall", 32'({tx_a, busy_a, cnt_a}), 32'({1'b0, 1'b1, 5'd0}));
        measure_busy(n_busy);
        check("single_busy_cycles", 32'(n_busy), 32'(FRAME_CYC));
        wait_idle(1'b0, "single_timeout");
`ifdef UART_TX_PARITY_EN
        check("single_line_bits", 32'(last_bits_a), 32'(11'b10010010000));
`else
        check("single_line_bits", 32'(last_bits_a[9:0]), 32'(10'b1010010000));
`endif
        check("single_frames", 32'(frames_a), 32'd1);

        // ---------------- burst "Hello\r\n" ----------------
        @(posedge clk); #1;
        peak = 0;
        n_busy = 0;
        fork
            begin
                for (int i = 0; i < 7; i++) wr(1'b0, hello[i], 1'b1);
            end
            begin
                repeat (20) begin
                    @(negedge clk);
                    if (int'(cnt_a) > peak) peak = int'(cnt_a);
                end
            end
            begin
                int g = 0;
                while (busy_a !== 1'b1 && g < 50) begin @(negedge clk); g++; end
                measure_busy(n_busy);
            end
        join
        check("burst_peak_count", 32'(peak), 32'd6);
        check("burst_busy_cycles", 32'(n_busy), 32'(7 * FRAME_CYC));
        wait_idle(1'b0, "burst_timeout");
        check("burst_frames", 32'(frames_a), 32'd8);

        // ---------------- full / overflow on depth-4 instance ----------------
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) wr(1'b1, 8'h30 + 8'(i), 1'b1);
        @(negedge clk);
        check("full_ready_count", 32'({wr_ready_b, cnt_b, ovf_b}), 32'({1'b0, 3'd4, 1'b0}));
        wr(1'b1, 8'h35, 1'b0);
        @(negedge clk);
        check("overflow_set", 32'({wr_ready_b, cnt_b, ovf_b}), 32'({1'b0, 3'd4, 1'b1}));
        wait_idle(1'b1, "overflow_timeout");
        check("overflow_frames", 32'(frames_b), 32'd5);
        check("overflow_sticky", 32'(ovf_b), 32'd1);

        // ---------------- simultaneous push/pop at STOP end ----------------
        @(posedge clk); #1;
        wr(1'b0, 8'hC3, 1'b1);
        wr(1'b0, 8'h3C, 1'b1);
        wr(1'b0, 8'h81, 1'b1);
        repeat (FRAME_CYC - 2) @(posedge clk);
        #1;
        @(negedge clk);
        check("pre_collision_count", 32'({cnt_a, tx_a}), 32'({5'd2, 1'b1}));
        wr(1'b0, 8'h7E, 1'b1);
        @(negedge clk);
        check("collision_count", 32'({cnt_a, tx_a, busy_a}), 32'({5'd2, 1'b0, 1'b1}));
        wait_idle(1'b0, "collision_timeout");
        check("collision_frames", 32'(frames_a), 32'd12);

        // ---------------- reset mid-frame ----------------
        @(posedge clk); #1;
        wr(1'b0, 8'hA5, 1'b0);
        wr(1'b0, 8'h11, 1'b0);
        wr(1'b0, 8'h22, 1'b0);
        wr(1'b0, 8'h33, 1'b0);
        @(negedge clk);
        check("queued_three", 32'(cnt_a), 32'd3);
        repeat (43) @(posedge clk);
        #2;
        check("data_bit3_low", 32'(tx_a), 32'd0);
        rst_a = 1'b1;
        #1;
        check("async_reset_line", 32'({tx_a, cnt_a, busy_a}), 32'({1'b1, 5'd0, 1'b0}));
        repeat (3) @(posedge clk);
        #1;
        rst_a = 1'b0;
        hi = 0;
        repeat (300) begin
            @(negedge clk);
            if (busy_a || !tx_a || cnt_a != 5'd0) hi++;
        end
        check("quiet_after_reset", 32'(hi), 32'd0);
        @(posedge clk); #1;
        wr(1'b0, 8'h5A, 1'b1);
        wait_idle(1'b0, "post_reset_timeout");
        check("post_reset_frames", 32'(frames_a), 32'd13);

`ifdef UART_TX_PARITY_EN
        // ---------------- parity: 0x07 has odd weight ----------------
        @(posedge clk); #1;
        wr(1'b0, 8'h07, 1'b1);
        @(negedge clk);
        @(negedge clk);
        measure_busy(n_busy);
        check("parity_busy_cycles", 32'(n_busy), 32'd110);
        wait_idle(1'b0, "parity_timeout");
        check("parity_line_bits", 32'(last_bits_a), 32'({1'b1, 1'b1, 8'h07, 1'b0}));
        check("parity_frames", 32'(frames_a), 32'd14);
`endif

        check("queue_a_drained", 32'(exp_a.size()), 32'd0);
        check("queue_b_drained", 32'(exp_b.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
